fwd_ctrl_unit: RTL and testbench
================================

// Module: fwd_ctrl_unit
// PURPOSE
//  Forwarding/hazard controller for the 5-stage pipeline; generates the 2-bit selectors consumed by the EX-stage operand muxes.
//  Tracks destination-register info of in-flight instructions (EX/MEM/WB), registers per-operand forward selects for the
//  instruction entering EX, and raises a load-use stall. Sits beside the ID/EX pipeline register; driven by decode.
// PARAMETERS
//  REG_ADDR_W  5   register-address width (x0..x31)
//  CNT_W       32  stall-counter width (FWD_STALL_CNT_EN only)
// PORTS
//  clk           in   1           pipeline clock, rising edge
//  reset_n       in   1           asynchronous, active-low reset
//  id_valid      in   1           ID holds a real instruction
//  id_rs1        in   REG_ADDR_W  ID source reg 1
//  id_rs2        in   REG_ADDR_W  ID source reg 2
//  id_rd         in   REG_ADDR_W  ID destination reg
//  id_reg_write  in   1           ID instruction writes rd
//  id_mem_read   in   1           ID instruction is a load
//  flush         in   1           squash the ID instruction (taken branch/jump)
//  fwd_sel_a     out  2           EX operand-A select: 0=regfile, 1=MEM-stage result, 2=WB-stage result
//  fwd_sel_b     out  2           EX operand-B select, same encoding
//  hazard_stall  out  1           hold PC and IF/ID; insert bubble into EX (combinational)
//  stall_count   out  CNT_W       cycles stalled (FWD_STALL_CNT_EN only)
// BEHAVIOUR
//  - Internal stage records EX, MEM, WB: {valid, rd, reg_write, mem_read}. reset_n low -> all cleared; fwd_sel_a/b=0;
//    hazard_stall=0; stall_count=0. Reset mid-operation discards in-flight records immediately (async).
//  - hazard_stall = id_valid & ex.valid & ex.mem_read & ex.rd!=0 & (ex.rd==id_rs1 | ex.rd==id_rs2) & ~flush.
//  - Each rising clk: WB<=MEM; MEM<=EX; EX<=bubble if (hazard_stall|flush|~id_valid), else ID fields.
//  - Select for operand X (rs = id_rs1/id_rs2), computed from ID and registered into fwd_sel_X with EX update:
//      rs==0                                     -> 0 (x0 never forwarded)
//      ex.valid & ex.reg_write & ex.rd==rs       -> 1 (producer will be in MEM)
//      mem.valid & mem.reg_write & mem.rd==rs    -> 2 (producer will be in WB)
//      otherwise                                 -> 0
//    Newest producer wins when EX and MEM both match. Bubble into EX -> fwd_sel_a/b=0.
//  - Latency: selects valid in the cycle the instruction occupies EX (1 clk after ID evaluation).
//  - Load-use: stall exactly 1 cycle; next cycle the load is in MEM, ID re-evaluates and selects 2.
//  - Load producer in MEM at evaluation (two apart) -> select 2, no stall.
//  - flush & hazard conditions same cycle: flush wins; hazard_stall=0; EX gets bubble.
//  - WB record only ages out; regfile write-before-read covers distance-3 dependencies (no select).
//  - Encoding 3 never driven.
// CONFIGURATION
//  FWD_STALL_CNT_EN defined: stall_count port present; +1 each clk with hazard_stall=1; saturates at all-ones;
//    cleared only by reset_n.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. reset_n=0 mid-stream with EX=load x5 -> fwd_sel_a/b=0, hazard_stall=0 immediately; after release no stale forward.
//  2. add x5 then add x6,x5,x5 back-to-back -> next clk fwd_sel_a=1, fwd_sel_b=1, no stall.
//  3. add x5; nop; sub x7,x1,x5 -> sub in EX: fwd_sel_a=0, fwd_sel_b=2.
//  4. lw x5; add x6,x5,x2 -> hazard_stall=1 one cycle, EX bubble with sels 0; then add in EX: fwd_sel_a=2, fwd_sel_b=0.
//  5. add x0,...; add x3,x0,x0 -> sels 0. add x5; add x5; use x5 -> sel 1 (newest).
//  6. lw x5 in EX, ID uses x5, flush=1 -> hazard_stall=0, bubble; with FWD_STALL_CNT_EN stall_count unchanged,
//     and 3 real stalls -> stall_count=3.

Source files
------------

// File: rtl/fwd_ctrl_unit.sv
// Forwarding/hazard controller: registered EX operand forward selects and a combinational load-use stall.
// Define FWD_STALL_CNT_EN to add the saturating stall_count output.
module fwd_ctrl_unit #(
  parameter int unsigned REG_ADDR_W = 5
`ifdef FWD_STALL_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  hazard_stall
`ifdef FWD_STALL_CNT_EN
  , output logic [CNT_W-1:0]    stall_count
`endif
);

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam sel_t SEL_RF  = SEL_W'(0);
  localparam sel_t SEL_MEM = SEL_W'(1);
  localparam sel_t SEL_WB  = SEL_W'(2);

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } ex_rec_t;

  ex_rec_t   ex_q;
  ex_rec_t   ex_d;
  // MEM only needs "will write rd"; the WB record would only age out, since the
  // regfile's write-before-read covers it, so it is not kept.
  logic      mem_wr_q;
  reg_addr_t mem_rd_q;

  logic      ex_bubble;
  logic      rs1_hit_ex;
  logic      rs2_hit_ex;
  sel_t      sel_a_d;
  sel_t      sel_b_d;

  // Newest producer wins: EX (moving to MEM) is checked before MEM (moving to WB).
  function automatic sel_t pick_sel(input reg_addr_t rs, input ex_rec_t ex,
                                    input logic mem_wr, input reg_addr_t mem_rd);
    sel_t sel;
    sel = SEL_RF;
    if (rs == '0) begin
      sel = SEL_RF;
    end else if (ex.valid && ex.reg_write && (ex.rd == rs)) begin
      sel = SEL_MEM;
    end else if (mem_wr && (mem_rd == rs)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  // Load-use detection, bubble decision and next EX record/selects.
  always_comb begin
    rs1_hit_ex   = (ex_q.rd == id_rs1);
    rs2_hit_ex   = (ex_q.rd == id_rs2);
    hazard_stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                   (rs1_hit_ex | rs2_hit_ex) & ~flush;
    ex_bubble    = hazard_stall | flush | ~id_valid;

    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!ex_bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      sel_a_d        = pick_sel(id_rs1, ex_q, mem_wr_q, mem_rd_q);
      sel_b_d        = pick_sel(id_rs2, ex_q, mem_wr_q, mem_rd_q);
    end
  end

  // Stage records advance every cycle; selects load with the EX record.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= '0;
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else begin
      mem_wr_q  <= ex_q.valid & ex_q.reg_write;
      mem_rd_q  <= ex_q.rd;
      ex_q      <= ex_d;
      fwd_sel_a <= sel_a_d;
      fwd_sel_b <= sel_b_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (hazard_stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: directed pipeline scenarios plus random traffic against an in-flight queue model.
module tb_fwd_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       hazard_stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] exp_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  fwd_ctrl_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .hazard_stall (hazard_stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
  } instr_t;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } rec_t;

  typedef struct {
    instr_t     i;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
  } step_t;

  // Instructions in flight after ID: [0] is in EX, [1] is in MEM.
  rec_t       pipe_q[$];
  logic       exp_st;
  logic [1:0] exp_a;
  logic [1:0] exp_b;

  function automatic instr_t mk(input int v, input int rs1, input int rs2, input int rd,
                                input int rw, input int mr, input int fl);
    instr_t i;
    i.v = 1'(v); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
    i.rw = 1'(rw); i.mr = 1'(mr); i.fl = 1'(fl);
    return i;
  endfunction

  function automatic rec_t bubble_rec();
    rec_t r;
    r.v = 1'b0; r.rd = '0; r.rw = 1'b0; r.mr = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    pipe_q.push_back(bubble_rec());
    pipe_q.push_back(bubble_rec());
    exp_st = 1'b0;
    exp_a  = 2'd0;
    exp_b  = 2'd0;
`ifdef FWD_STALL_CNT_EN
    exp_cnt = '0;
`endif
  endtask

  // Source select from the forwarding rules: x0 never, younger producer first.
  function automatic logic [1:0] ref_sel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (pipe_q[0].v && pipe_q[0].rw && pipe_q[0].rd == rs) return 2'd1;
    if (pipe_q[1].v && pipe_q[1].rw && pipe_q[1].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Present one ID instruction for a cycle; returns stall before the edge and selects after it.
  task automatic cyc(input instr_t i, output logic st, output logic [1:0] sa, output logic [1:0] sb);
    rec_t       nxt;
    logic       bub;
    logic [1:0] na;
    logic [1:0] nb;
    @(negedge clk);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_reg_write = i.rw; id_mem_read = i.mr; flush = i.fl;
    exp_st = i.v && pipe_q[0].v && pipe_q[0].mr && (pipe_q[0].rd != 5'd0) &&
             (pipe_q[0].rd == i.rs1 || pipe_q[0].rd == i.rs2) && !i.fl;
    bub = exp_st || i.fl || !i.v;
    if (bub) begin
      nxt = bubble_rec(); na = 2'd0; nb = 2'd0;
    end else begin
      nxt.v = 1'b1; nxt.rd = i.rd; nxt.rw = i.rw; nxt.mr = i.mr;
      na = ref_sel(i.rs1); nb = ref_sel(i.rs2);
    end
    #1 st = hazard_stall;
    @(posedge clk);
    pipe_q.push_front(nxt);
    void'(pipe_q.pop_back());
    exp_a = na;
    exp_b = nb;
`ifdef FWD_STALL_CNT_EN
    if (exp_st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    #1;
    sa = fwd_sel_a;
    sb = fwd_sel_b;
  endtask

  task automatic drain();
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    repeat (2) cyc(mk(0, 0, 0, 0, 0, 0, 0), st, sa, sb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    vectors++;
    if (hazard_stall !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state stall=%0b sel_a=%0d sel_b=%0d want 0/0/0", hazard_stall, fwd_sel_a, fwd_sel_b);
    end
`ifdef FWD_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count got=%0d want=0", stall_count);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    // add x1 then lw x5,0(x1): the load sits in EX with sel_a=1.
    cyc(mk(1, 2, 3, 1, 1, 0, 0), st, sa, sb);
    cyc(mk(1, 1, 0, 5, 1, 1, 0), st, sa, sb);
    vectors++;
    if (sa !== 2'd1) begin
      miscompares++; $display("FAIL reset_setup sel_a got=%0d want=1", sa);
    end
    @(negedge clk);
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd6;
    id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      miscompares++; $display("FAIL reset_pre_stall got=%0b want=1", hazard_stall);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (hazard_stall !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async stall=%0b sel_a=%0d sel_b=%0d want 0/0/0", hazard_stall, fwd_sel_a, fwd_sel_b);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(mk(1, 5, 5, 6, 1, 0, 0), st, sa, sb);
    vectors++;
    if (st !== 1'b0 || sa !== 2'd0 || sb !== 2'd0) begin
      miscompares++; $display("FAIL reset_stale stall=%0b sel_a=%0d sel_b=%0d want 0/0/0", st, sa, sb);
    end
  endtask

  task automatic test_back_to_back();
    step_t      s[2];
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    drain();
    s[0] = '{mk(1, 1, 2, 5, 1, 0, 0), 1'b0, 2'd0, 2'd0};
    s[1] = '{mk(1, 5, 5, 6, 1, 0, 0), 1'b0, 2'd1, 2'd1};
    foreach (s[k]) begin
      cyc(s[k].i, st, sa, sb);
      vectors++;
      if (st !== s[k].st || sa !== s[k].a || sb !== s[k].b) begin
        miscompares++;
        $display("FAIL b2b[%0d] got stall=%0b a=%0d b=%0d want %0b/%0d/%0d", k, st, sa, sb, s[k].st, s[k].a, s[k].b);
      end
    end
  endtask

  task automatic test_distance2();
    step_t      s[3];
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    drain();
    s[0] = '{mk(1, 1, 2, 5, 1, 0, 0), 1'b0, 2'd0, 2'd0};
    s[1] = '{mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 2'd0, 2'd0};
    s[2] = '{mk(1, 1, 5, 7, 1, 0, 0), 1'b0, 2'd0, 2'd2};
    foreach (s[k]) begin
      cyc(s[k].i, st, sa, sb);
      vectors++;
      if (st !== s[k].st || sa !== s[k].a || sb !== s[k].b) begin
        miscompares++;
        $display("FAIL dist2[%0d] got stall=%0b a=%0d b=%0d want %0b/%0d/%0d", k, st, sa, sb, s[k].st, s[k].a, s[k].b);
      end
    end
  endtask

  task automatic test_load_use();
    step_t      s[6];
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    drain();
    s[0] = '{mk(1, 1, 0, 5, 1, 1, 0), 1'b0, 2'd0, 2'd0};  // lw x5
    s[1] = '{mk(1, 5, 2, 6, 1, 0, 0), 1'b1, 2'd0, 2'd0};  // add x6,x5,x2 stalls, bubble
    s[2] = '{mk(1, 5, 2, 6, 1, 0, 0), 1'b0, 2'd2, 2'd0};  // re-evaluated, load in MEM
    s[3] = '{mk(1, 1, 0, 8, 1, 1, 0), 1'b0, 2'd0, 2'd0};  // lw x8
    s[4] = '{mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 2'd0, 2'd0};
    s[5] = '{mk(1, 2, 8, 9, 1, 0, 0), 1'b0, 2'd0, 2'd2};  // two apart: no stall
    foreach (s[k]) begin
      cyc(s[k].i, st, sa, sb);
      vectors++;
      if (st !== s[k].st || sa !== s[k].a || sb !== s[k].b) begin
        miscompares++;
        $display("FAIL load_use[%0d] got stall=%0b a=%0d b=%0d want %0b/%0d/%0d", k, st, sa, sb, s[k].st, s[k].a, s[k].b);
      end
    end
  endtask

  task automatic test_x0_newest();
    step_t      s[7];
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    drain();
    s[0] = '{mk(1, 1, 2, 0, 1, 0, 0), 1'b0, 2'd0, 2'd0};  // add x0,x1,x2
    s[1] = '{mk(1, 0, 0, 3, 1, 0, 0), 1'b0, 2'd0, 2'd0};  // add x3,x0,x0
    s[2] = '{mk(1, 1, 0, 0, 1, 1, 0), 1'b0, 2'd0, 2'd0};  // lw x0
    s[3] = '{mk(1, 0, 0, 1, 1, 0, 0), 1'b0, 2'd0, 2'd0};  // use x0: no stall
    s[4] = '{mk(1, 1, 2, 5, 1, 0, 0), 1'b0, 2'd1, 2'd0};  // add x5,x1,x2 (x1 in EX)
    s[5] = '{mk(1, 2, 4, 5, 1, 0, 0), 1'b0, 2'd0, 2'd0};  // add x5 again
    s[6] = '{mk(1, 5, 5, 7, 1, 0, 0), 1'b0, 2'd1, 2'd1};  // newest producer wins
    foreach (s[k]) begin
      cyc(s[k].i, st, sa, sb);
      vectors++;
      if (st !== s[k].st || sa !== s[k].a || sb !== s[k].b) begin
        miscompares++;
        $display("FAIL x0_newest[%0d] got stall=%0b a=%0d b=%0d want %0b/%0d/%0d", k, st, sa, sb, s[k].st, s[k].a, s[k].b);
      end
    end
  endtask

  task automatic test_flush();
    step_t      s[3];
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    do_reset();
    s[0] = '{mk(1, 1, 0, 5, 1, 1, 0), 1'b0, 2'd0, 2'd0};  // lw x5
    s[1] = '{mk(1, 5, 5, 6, 1, 0, 1), 1'b0, 2'd0, 2'd0};  // hazard + flush: flush wins
    s[2] = '{mk(1, 5, 5, 6, 1, 0, 0), 1'b0, 2'd2, 2'd2};
    foreach (s[k]) begin
      cyc(s[k].i, st, sa, sb);
      vectors++;
      if (st !== s[k].st || sa !== s[k].a || sb !== s[k].b) begin
        miscompares++;
        $display("FAIL flush[%0d] got stall=%0b a=%0d b=%0d want %0b/%0d/%0d", k, st, sa, sb, s[k].st, s[k].a, s[k].b);
      end
    end
`ifdef FWD_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'd0) begin
      miscompares++; $display("FAIL flush_count got=%0d want=0", stall_count);
    end
`endif
    for (int n = 0; n < 3; n++) begin
      cyc(mk(1, 1, 0, 5, 1, 1, 0), st, sa, sb);
      cyc(mk(1, 5, 2, 6, 1, 0, 0), st, sa, sb);
      vectors++;
      if (st !== 1'b1) begin
        miscompares++; $display("FAIL flush_real_stall[%0d] got=%0b want=1", n, st);
      end
      cyc(mk(1, 5, 2, 6, 1, 0, 0), st, sa, sb);
    end
`ifdef FWD_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'd3) begin
      miscompares++; $display("FAIL stall_count3 got=%0d want=3", stall_count);
    end
`endif
  endtask

  task automatic test_random();
    instr_t     i;
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       held = 1'b0;
    i = mk(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      // A stalled instruction is presented again, as decode would hold it.
      if (!held) begin
        i.v   = ($urandom_range(9) != 0);
        i.rs1 = 5'($urandom_range(3));
        i.rs2 = 5'($urandom_range(3));
        i.rd  = 5'($urandom_range(3));
        i.rw  = ($urandom_range(3) != 0);
        i.mr  = i.rw && ($urandom_range(2) == 0);
      end
      i.fl = ($urandom_range(9) == 0);
      cyc(i, st, sa, sb);
      held = exp_st;
      vectors++;
      if (st !== exp_st) begin
        miscompares++; $display("FAIL rand[%0d] stall got=%0b want=%0b", n, st, exp_st);
      end
      vectors++;
      if (sa !== exp_a || sb !== exp_b) begin
        miscompares++; $display("FAIL rand[%0d] sels got=%0d/%0d want=%0d/%0d", n, sa, sb, exp_a, exp_b);
      end
`ifdef FWD_STALL_CNT_EN
      vectors++;
      if (stall_count !== exp_cnt) begin
        miscompares++; $display("FAIL rand[%0d] count got=%0d want=%0d", n, stall_count, exp_cnt);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_x0_newest();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
